// File: rtl/keccak_arbiter.sv
// keccak_arbiter
//   Shares one SHA3-512 core between two message requesters. A requester is
//   granted by round robin, the core is cleared for one cycle, the granted
//   requester's words are streamed through to the core, and the digest is
//   held for the owner until it acknowledges.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester word handshake
//   req_data0/1           64-bit message words (first byte in bits 63:56)
//   req_last, req_bytes0/1 last-word flag and valid byte count of last word
//   dig_valid/dig_data/dig_ack  per-requester digest handshake
//   core_*                interface to the shared SHA3-512 core
//   grant                 index of the requester owning the core
//   word_cnt              words accepted in the current message (saturating)
module keccak_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    input  logic [63:0]      req_data0,
    input  logic [63:0]      req_data1,
    input  logic [1:0]       req_last,
    input  logic [2:0]       req_bytes0,
    input  logic [2:0]       req_bytes1,
    output logic [1:0]       req_ready,
    output logic [1:0]       dig_valid,
    output logic [511:0]     dig_data,
    input  logic [1:0]       dig_ack,
    output logic             core_reset,
    output logic [63:0]      core_in,
    output logic             core_in_ready,
    output logic             core_is_last,
    output logic [2:0]       core_byte_num,
    input  logic             core_buffer_full,
    input  logic [511:0]     core_out,
    input  logic             core_out_ready,
    output logic             grant,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        FEED = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;
    logic   last_served;
    logic   accept;
    logic   pick;

    // Word handshake completes only in FEED, for the owner, when the core has room.
    assign accept = (state == FEED) && req_valid[grant] && !core_buffer_full;

    // Round robin: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        pick = 1'b0;
        case (req_valid)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_served;
            default: pick = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_served <= 1'b1;
            word_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        state <= CLR;
                    end
                end
                CLR: begin
                    word_cnt <= '0;
                    state    <= FEED;
                end
                FEED: begin
                    if (accept) begin
                        if (word_cnt != '1)
                            word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (req_last[grant])
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_out_ready)
                        state <= DONE;
                end
                DONE: begin
                    if (dig_ack[grant]) begin
                        last_served <= grant;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // core_reset is also held while reset_n is low so the core starts clean.
    assign core_reset = !reset_n || (state == CLR);

    always_comb begin
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        if ((state == FEED) && req_valid[grant]) begin
            core_in_ready = 1'b1;
            core_in       = grant ? req_data1 : req_data0;
            core_is_last  = req_last[grant];
            core_byte_num = grant ? req_bytes1 : req_bytes0;
        end
    end

    always_comb begin
        req_ready = '0;
        dig_valid = '0;
        dig_data  = '0;
        if (state == FEED)
            req_ready[grant] = !core_buffer_full;
        if (state == DONE) begin
            dig_valid[grant] = 1'b1;
            dig_data         = core_out;
        end
    end

endmodule
